// File: rtl/glyph_fetch.sv
// glyph_fetch: scanline fetch sequencer for the character generator ROM.
// Walks one text row of video RAM per scanline, turns each character code
// into a glyph ROM address for the current cell line, and queues the
// returned glyph bytes in a 2-entry first-word-fall-through FIFO.
// Optional cursor inversion is compiled in with `define GLYPH_FETCH_CURSOR_EN.
module glyph_fetch #(
  parameter int COLS    = 80,
  parameter int VADDR_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               font_8x8,
  input  logic               line_start,
  input  logic [4:0]         text_row,
  input  logic [3:0]         glyph_line,
  output logic [VADDR_W-1:0] vram_addr,
  input  logic [7:0]         vram_data,
  output logic [11:0]        rom_addr,
  input  logic [7:0]         rom_data,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
`ifdef GLYPH_FETCH_CURSOR_EN
  ,
  input  logic               cursor_en,
  input  logic [4:0]         cursor_row,
  input  logic [6:0]         cursor_col,
  input  logic               blink
`endif
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, GLYPH} state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  state_t      state_reg;
  logic        font_reg;
  logic [4:0]  row_reg;
  logic [3:0]  line_reg;
  logic [6:0]  col_reg;

  // FIFO storage: slot 0 is always the head
  logic [7:0]  slot_data [2];
  logic        slot_last [2];
  logic [1:0]  count_reg;

  logic        pop;
  logic        push;
  logic        flush;
  logic [1:0]  wr_idx;
  logic [7:0]  glyph_byte;

  // Start address of a text row; wraps naturally in VADDR_W bits
  function automatic logic [VADDR_W-1:0] row_base(input logic [4:0] row);
    return VADDR_W'(row) * VADDR_W'(COLS);
  endfunction

  assign busy      = (state_reg != IDLE);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = slot_data[0];
  assign out_last  = slot_last[0];

  assign pop   = out_valid & out_ready;
  // A new line_start while busy throws away the line in progress
  assign flush = line_start & busy;
  // Abort takes priority over a push landing on the same edge
  assign push  = (state_reg == GLYPH) & ~line_start & ((count_reg != 2'd2) | pop);
  // Slots shift down on a pop, so the write slot is the post-pop occupancy
  assign wr_idx = count_reg - {1'b0, pop};

  // Glyph byte to push: blank gap lines in 8x8 mode, optional cursor inversion
  always_comb begin
    glyph_byte = (font_reg && line_reg[3]) ? 8'h00 : rom_data;
`ifdef GLYPH_FETCH_CURSOR_EN
    if (cursor_en && blink && (row_reg == cursor_row) && (col_reg == cursor_col))
      glyph_byte = ~glyph_byte;
`endif
  end

  // Fetch sequencer: one character every ADDR -> WAIT -> GLYPH pass
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      font_reg  <= 1'b0;
      row_reg   <= 5'd0;
      line_reg  <= 4'd0;
      col_reg   <= 7'd0;
      vram_addr <= '0;
      rom_addr  <= 12'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (line_start) begin
        // Same path for a fresh start and an abort restart
        font_reg  <= font_8x8;
        row_reg   <= text_row;
        line_reg  <= glyph_line;
        col_reg   <= 7'd0;
        vram_addr <= row_base(text_row);
        state_reg <= ADDR;
      end else begin
        case (state_reg)
          ADDR: state_reg <= WAIT;
          WAIT: begin
            if (font_reg)
              rom_addr <= {2'b00, vram_data[6:0], line_reg[2:0]};
            else
              rom_addr <= {vram_data, line_reg};
            state_reg <= GLYPH;
          end
          GLYPH: begin
            // Without a push the state and rom_addr simply hold (stall)
            if (push) begin
              if (col_reg == LAST_COL) begin
                done      <= 1'b1;
                state_reg <= IDLE;
              end else begin
                col_reg   <= col_reg + 7'd1;
                vram_addr <= vram_addr + VADDR_W'(1);
                state_reg <= ADDR;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Two-entry FWFT FIFO: shift on pop, write at the first free slot
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        slot_data[i] <= 8'h00;
        slot_last[i] <= 1'b0;
      end
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      if (pop) begin
        slot_data[0] <= slot_data[1];
        slot_last[0] <= slot_last[1];
      end
      if (push) begin
        slot_data[wr_idx[0]] <= glyph_byte;
        slot_last[wr_idx[0]] <= (col_reg == LAST_COL);
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
